md_hilo_ctrl: RTL and testbench
===============================

# md_hilo_ctrl

Multi-cycle multiply/divide controller that owns the architectural HI/LO registers for the 5-stage MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from the EX stage and sequences an iterative 32-step shift-add multiplier or restoring divider. It raises `stallreq` to the pipeline controller while busy. It publishes the HI/LO write forwarding bus that ID consumes for mfhi/mflo.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1 — core clock.
- `resetn` in 1 — asynchronous, active-low reset.
- `flush` in 1 — abort the current operation; no HI/LO write.
- `start` in 1 — the EX stage holds a valid HI/LO instruction this cycle.
- `md_op` in 6 — {div, divu, mult, multu, mthi, mtlo}, same order as the ID hilo bus.
  - Expected one-hot.
  - If several bits are set, priority is div > divu > mult > multu > mthi > mtlo.
- `src1` in 32 — rs value (dividend / multiplicand / mthi-mtlo source).
- `src2` in 32 — rt value (divisor / multiplier).
- `stallreq` out 1 — request to stall IF..EX.
- `busy` out 1 — FSM is not IDLE.
- `hilo_we` out 2 — {HI write, LO write} taking effect at the end of this cycle; forwarding bus to ID.
- `hi_i` out 32 — HI value being written.
- `lo_i` out 32 — LO value being written.
- `hi_o` out 32 — architectural HI register.
- `lo_o` out 32 — architectural LO register.

## Operation
- FSM states: IDLE, BUSY, FIX, DONE.
- Reset (async, `resetn`=0):
  - State = IDLE, iteration counter = 0.
  - HI = LO = 0; result and operand registers = 0.
  - All outputs 0.
- IDLE:
  - `start` with mthi: `hilo_we`=10, `hi_i`=`src1`; HI updates at the clock edge. No stall.
  - `start` with mtlo: `hilo_we`=01, `lo_i`=`src1`; LO updates at the clock edge. No stall.
  - `start` with a mul/div op:
    - Latch |`src1|` and |`src2|` (raw values for divu/multu).
    - Latch the op, `src1[31]` and `src2[31]`; clear the counter; go to BUSY.
- BUSY: one iteration per cycle; counter runs 0..31; after iteration 31 go to FIX.
  - Multiply uses a 64-bit product register {acc, multiplier}:
    - If the LSB is 1, acc += multiplicand (33-bit add including carry).
    - Then shift the 65-bit value right by 1.
  - Divide (restoring) uses a 64-bit register {rem, quot}:
    - Shift left by 1.
    - Trial-subtract the divisor from the upper 33 bits.
    - If the result is non-negative, keep it and set the quotient LSB to 1.
- FIX: one cycle of sign correction into the result registers, then go to DONE.
  - mult: negate the 64-bit product when the operand signs differ.
  - div: negate the quotient when the signs differ; negate the remainder when the dividend is negative.
  - multu/divu: no correction.
- DONE: one cycle, then go to IDLE unconditionally. `start` is ignored in DONE (the same instruction is still in EX).
  - `hilo_we`=11.
  - mult/multu: `hi_i`=product[63:32], `lo_i`=product[31:0].
  - div/divu: `hi_i`=remainder, `lo_i`=quotient.
  - HI/LO update at the end of DONE.
- Divide by zero is deterministic, not trapped:
  - Unsigned magnitude result is quotient 0xFFFFFFFF, remainder = dividend magnitude.
  - The FIX sign rules then apply.
- `flush`:
  - In BUSY or FIX: go to IDLE next edge; no write.
  - In DONE: suppresses `hilo_we` (forced to 00); no write.
  - In IDLE: suppresses mthi/mtlo and suppresses any start.
- `stallreq` = (IDLE & `start` & mul/div op & !`flush`) | BUSY | FIX. It is combinational from `start`.
- `hilo_we`, `hi_i`, `lo_i` are 0 whenever no write occurs.

## Timing
- mthi/mtlo:
  - Zero stall.
  - Forwarding is visible in the issue cycle.
  - `hi_o`/`lo_o` show the new value the next cycle.
- mul/div timeline (issue cycle = c0):
  - `stallreq`=1 in cycles c0..c33: issue, 32 BUSY cycles, FIX.
  - c34 is DONE: `stallreq`=0, `hilo_we`=11.
  - `hi_o`/`lo_o` are valid from c35.
- An mfhi/mflo in ID during c34 must pick up `hi_i`/`lo_i` through the forwarding bus.
- Back-to-back mul/div: the next `start` is accepted at c35 (IDLE) with no bubble beyond the stall.
- Reset asserted mid-operation clears everything immediately. No partial HI/LO write is possible.

## Test plan
- multu `src1`=0xFFFFFFFF, `src2`=2:
  - `stallreq` high for exactly 34 cycles.
  - DONE shows `hilo_we`=11; then HI=0x00000001, LO=0xFFFFFFFE.
- mult -3 × 5: HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also mult 0x80000000 × 0x80000000: HI=0x40000000, LO=0.
- div:
  - -7 / 2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7 / 0 gives LO=0xFFFFFFFF, HI=7.
  - div -7 / 0 gives LO=0x00000001, HI=0xFFFFFFF9.
- mthi 0x12345678 followed immediately by mtlo 0xCAFEBABE:
  - No stall; `hilo_we`=10, then 01.
  - `hi_o`/`lo_o` update one cycle after each write.
- `flush` asserted in BUSY cycle 10 of a divu:
  - `stallreq` drops the next cycle; FSM returns to IDLE.
  - HI/LO are unchanged; a new multu issued afterwards completes correctly.
- `resetn` pulsed low asynchronously mid-BUSY:
  - All outputs 0 immediately and HI=LO=0.
  - After release, `start` with mult 6 × 7 yields LO=42, HI=0.

Source files
------------

// File: rtl/md_hilo_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO registers.
// Runs a 32-step shift-add multiplier or restoring divider, then one sign-fix cycle.
module md_hilo_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        start,
  input  logic [5:0]  md_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic        busy,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_i,
  output logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        sgn_q, sgn_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // md_op = {div, divu, mult, multu, mthi, mtlo}; higher bits win
  logic        is_muldiv, is_div, is_signed, wr_mthi, wr_mtlo, issue;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    is_muldiv = |md_op[5:2];
    is_div    = md_op[5] | md_op[4];
    is_signed = md_op[5] | (md_op[5:4] == 2'b00 && md_op[3]);
    wr_mthi   = (md_op[5:2] == 4'b0000) && md_op[1];
    wr_mtlo   = (md_op[5:1] == 5'b00000) && md_op[0];
    a_mag     = (is_signed && src1[31]) ? (32'd0 - src1) : src1;
    b_mag     = (is_signed && src2[31]) ? (32'd0 - src2) : src2;
    issue     = (state_q == ST_IDLE) && start && !flush && is_muldiv;
  end

  logic [32:0] mul_sum;
  logic [63:0] mul_step, div_step, neg_prod;
  logic [31:0] div_diff;
  logic        div_keep;

  always_comb begin
    mul_sum  = {1'b0, work_q[63:32]} + {1'b0, opnd_q};
    mul_step = work_q[0] ? {mul_sum, work_q[31:1]} : {1'b0, work_q[63:1]};
    // Trial subtract on the shifted upper 33 bits; a kept result always fits in 32
    div_keep = work_q[63:31] >= {1'b0, opnd_q};
    div_diff = work_q[62:31] - opnd_q;
    div_step = div_keep ? {div_diff, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};
    neg_prod = 64'd0 - work_q;
  end

  logic [1:0]  we_w;
  logic [31:0] hi_w, lo_w;

  always_comb begin
    we_w = 2'b00;
    hi_w = 32'd0;
    lo_w = 32'd0;
    if (state_q == ST_IDLE && start && !flush) begin
      if (wr_mthi) begin
        we_w = 2'b10;
        hi_w = src1;
      end else if (wr_mtlo) begin
        we_w = 2'b01;
        lo_w = src1;
      end
    end else if (state_q == ST_DONE && !flush) begin
      we_w = 2'b11;
      hi_w = res_hi_q;
      lo_w = res_lo_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = we_w[1] ? hi_w : hi_q;
    lo_d     = we_w[0] ? lo_w : lo_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          cnt_d   = 5'd0;
          div_d   = is_div;
          sgn_d   = is_signed;
          s1_d    = src1[31];
          s2_d    = src2[31];
          work_d  = {32'd0, is_div ? a_mag : b_mag};
          opnd_d  = is_div ? b_mag : a_mag;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          work_d = div_q ? div_step : mul_step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (div_q) begin
            res_lo_d = (sgn_q && (s1_q ^ s2_q)) ? (32'd0 - work_q[31:0]) : work_q[31:0];
            res_hi_d = (sgn_q && s1_q) ? (32'd0 - work_q[63:32]) : work_q[63:32];
          end else begin
            {res_hi_d, res_lo_d} = (sgn_q && (s1_q ^ s2_q)) ? neg_prod : work_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      div_q    <= 1'b0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      work_q   <= 64'd0;
      opnd_q   <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Combinational outputs are held at zero while reset is asserted
  always_comb begin
    stallreq = resetn && (issue || state_q == ST_BUSY || state_q == ST_FIX);
    busy     = resetn && (state_q != ST_IDLE);
    hilo_we  = resetn ? we_w : 2'b00;
    hi_i     = resetn ? hi_w : 32'd0;
    lo_i     = resetn ? lo_w : 32'd0;
    hi_o     = hi_q;
    lo_o     = lo_q;
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: mul/div results, stall timing, mthi/mtlo, flush, reset.
module tb_md_hilo_ctrl;

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  md_op = 6'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        stallreq, busy;
  logic [1:0]  hilo_we;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  md_hilo_ctrl dut (
    .clk(clk), .resetn(resetn), .flush(flush), .start(start), .md_op(md_op),
    .src1(src1), .src2(src2), .stallreq(stallreq), .busy(busy), .hilo_we(hilo_we),
    .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Counts stalled cycles from the issue cycle; returns positioned in the first unstalled cycle
  task automatic wait_stall(output int n);
    n = 0;
    #1;
    while (stallreq === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = op; src1 = a; src2 = b;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s issue busy: got %b want 0", name, busy);
    end
    #0;
    wait_stall(n);
    checks++;
    if (n != 34) begin
      errors++; $display("FAIL %s stall cycles: got %0d want 34", name, n);
    end
    checks++;
    if (hilo_we !== 2'b11 || hi_i !== exp_hi || lo_i !== exp_lo) begin
      errors++;
      $display("FAIL %s done bus: got we=%b hi=%h lo=%h want we=11 hi=%h lo=%h",
               name, hilo_we, hi_i, lo_i, exp_hi, exp_lo);
    end
    $display("%s: a=%h b=%h stall=%0d hi_i=%h lo_i=%h", name, a, b, n, hi_i, lo_i);
  endtask

  task automatic finish_idle(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    @(negedge clk);
    start = 1'b0; md_op = 6'd0; flush = 1'b0;
    #1;
    checks++;
    if (hi_o !== exp_hi || lo_o !== exp_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hilo: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               name, hi_o, lo_o, busy, exp_hi, exp_lo);
    end
    $display("%s: hi_o=%h lo_o=%h", name, hi_o, lo_o);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (stallreq !== 1'b0 || busy !== 1'b0 || hilo_we !== 2'b00 || hi_i !== 32'd0 ||
        lo_i !== 32'd0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: got stall=%b busy=%b we=%b hi_i=%h lo_i=%h hi=%h lo=%h want all 0",
               stallreq, busy, hilo_we, hi_i, lo_i, hi_o, lo_o);
    end
    $display("reset: stall=%b busy=%b hi_o=%h lo_o=%h", stallreq, busy, hi_o, lo_o);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult;
    run_md(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu ffffffff*2");
    finish_idle(32'h00000001, 32'hFFFFFFFE, "multu ffffffff*2");
    run_md(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
    finish_idle(32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
    run_md(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min");
    finish_idle(32'h40000000, 32'h00000000, "mult min*min");
  endtask

  task automatic test_div;
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    finish_idle(32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_md(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu 7/0");
    finish_idle(32'd7, 32'hFFFFFFFF, "divu 7/0");
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001, "div -7/0");
    finish_idle(32'hFFFFFFF9, 32'h00000001, "div -7/0");
    // div and mult both set: div takes priority
    run_md(OP_DIV | OP_MULT, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, "prio div 100/-7");
    finish_idle(32'd2, 32'hFFFFFFF2, "prio div 100/-7");
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; src1 = 32'h12345678;
    #1;
    checks++;
    if (stallreq !== 1'b0 || hilo_we !== 2'b10 || hi_i !== 32'h12345678 || lo_i !== 32'd0) begin
      errors++;
      $display("FAIL mthi bus: got stall=%b we=%b hi_i=%h lo_i=%h want 0 10 12345678 0",
               stallreq, hilo_we, hi_i, lo_i);
    end
    $display("mthi: we=%b hi_i=%h", hilo_we, hi_i);
    @(negedge clk);
    md_op = OP_MTLO; src1 = 32'hCAFEBABE;
    #1;
    checks++;
    if (stallreq !== 1'b0 || hilo_we !== 2'b01 || lo_i !== 32'hCAFEBABE || hi_i !== 32'd0 ||
        hi_o !== 32'h12345678) begin
      errors++;
      $display("FAIL mtlo bus: got stall=%b we=%b hi_i=%h lo_i=%h hi_o=%h want 0 01 0 cafebabe 12345678",
               stallreq, hilo_we, hi_i, lo_i, hi_o);
    end
    $display("mtlo: we=%b lo_i=%h hi_o=%h", hilo_we, lo_i, hi_o);
    @(negedge clk);
    md_op = OP_MTHI | OP_MTLO; src1 = 32'h00000055;
    #1;
    checks++;
    if (hilo_we !== 2'b10 || hi_i !== 32'h55 || lo_o !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL mthi prio: got we=%b hi_i=%h lo_o=%h want 10 00000055 cafebabe",
               hilo_we, hi_i, lo_o);
    end
    $display("mthi|mtlo: we=%b hi_i=%h lo_o=%h", hilo_we, hi_i, lo_o);
    finish_idle(32'h00000055, 32'hCAFEBABE, "mthi/mtlo");
  endtask

  task automatic test_flush;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = OP_MTHI; src1 = 32'hDEADBEEF;
    #1;
    checks++;
    if (hilo_we !== 2'b00 || hi_i !== 32'd0) begin
      errors++; $display("FAIL flush idle mthi: got we=%b hi_i=%h want 00 0", hilo_we, hi_i);
    end
    @(negedge clk);
    md_op = OP_MULT; src1 = 32'd3; src2 = 32'd3;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL flush idle start: got stall=%b want 0", stallreq);
    end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi_o !== 32'h55) begin
      errors++; $display("FAIL flush idle state: got busy=%b hi_o=%h want 0 00000055", busy, hi_o);
    end
    $display("flush idle: busy=%b hi_o=%h", busy, hi_o);

    @(negedge clk);
    start = 1'b1; md_op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (stallreq !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL flush busy cycle: got stall=%b busy=%b want 1 1", stallreq, busy);
    end
    @(negedge clk);
    flush = 1'b0; start = 1'b0; md_op = 6'd0;
    #1;
    checks++;
    if (stallreq !== 1'b0 || busy !== 1'b0 || hilo_we !== 2'b00) begin
      errors++;
      $display("FAIL flush busy after: got stall=%b busy=%b we=%b want 0 0 00", stallreq, busy, hilo_we);
    end
    $display("flush busy: stall=%b busy=%b", stallreq, busy);
    finish_idle(32'h00000055, 32'hCAFEBABE, "flush busy hilo");
    run_md(OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, "multu after flush");
    finish_idle(32'd1, 32'd0, "multu after flush");
  endtask

  task automatic test_flush_done;
    int n;
    @(negedge clk);
    start = 1'b1; md_op = OP_MULTU; src1 = 32'd3; src2 = 32'd3;
    wait_stall(n);
    flush = 1'b1;
    #1;
    checks++;
    if (n != 34 || hilo_we !== 2'b00 || hi_i !== 32'd0 || lo_i !== 32'd0) begin
      errors++;
      $display("FAIL flush done: got stall=%0d we=%b hi_i=%h lo_i=%h want 34 00 0 0",
               n, hilo_we, hi_i, lo_i);
    end
    $display("flush done: we=%b", hilo_we);
    finish_idle(32'd1, 32'd0, "flush done hilo");
  endtask

  task automatic test_back_to_back;
    run_md(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "b2b mult 6*7");
    run_md(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "b2b divu 100/7");
    finish_idle(32'd2, 32'd14, "b2b divu 100/7");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; src1 = 32'hFFFFFFFD; src2 = 32'd5;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (stallreq !== 1'b0 || busy !== 1'b0 || hilo_we !== 2'b00 || hi_i !== 32'd0 ||
        lo_i !== 32'd0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset mid: got stall=%b busy=%b we=%b hi_i=%h lo_i=%h hi=%h lo=%h want all 0",
               stallreq, busy, hilo_we, hi_i, lo_i, hi_o, lo_o);
    end
    $display("reset mid: stall=%b busy=%b hi_o=%h lo_o=%h", stallreq, busy, hi_o, lo_o);
    @(negedge clk);
    start = 1'b0; md_op = 6'd0; resetn = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi_o !== 32'd0) begin
      errors++; $display("FAIL reset release: got busy=%b hi_o=%h want 0 0", busy, hi_o);
    end
    run_md(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult 6*7 after reset");
    finish_idle(32'd0, 32'd42, "mult 6*7 after reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_flush();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
